// File: rtl/vm2002_change_dispenser.sv
// vm2002_change_dispenser: greedy quarter/dime/nickel change payout from three coin tubes with refill.
// Optional CHG_EXACT_EN: dry-run the greedy payout first and refuse requests that cannot be paid exactly.
module vm2002_change_dispenser #(
    parameter int AMT_W     = 16,
    parameter int TUBE_W    = 6,
    parameter int TUBE_MAX  = 50,
    parameter int TUBE_INIT = 20,
    parameter int DISP_GAP  = 2
) (
    input  logic              clk,
    input  logic              hrst_n,
    input  logic              srst,
    input  logic              chg_valid,
    input  logic [AMT_W-1:0]  chg_amount,
    output logic              chg_ready,
    output logic              coin_strobe,
    output logic [1:0]        coin_out,
    output logic              done,
    output logic [AMT_W-1:0]  shortfall,
    output logic              exact_fail,
    input  logic              refill_valid,
    input  logic [1:0]        refill_coin,
    input  logic [TUBE_W-1:0] refill_count,
    output logic              refill_err,
    output logic [TUBE_W-1:0] tube_n,
    output logic [TUBE_W-1:0] tube_d,
    output logic [TUBE_W-1:0] tube_q
);
    localparam int GW = $clog2(DISP_GAP + 1);

    typedef enum logic [2:0] {
        IDLE, DISPENSE, GAP, DONE
`ifdef CHG_EXACT_EN
        , CHECK
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [AMT_W-1:0]  rem_q, rem_d, short_q, short_d;
    logic [TUBE_W-1:0] tn_q, tn_d, td_q, td_d, tq_q, tq_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              strobe_q, strobe_d, done_q, done_d, rerr_q, rerr_d, ready_q, ready_d;
    logic [1:0]        coin_q, coin_d, pc;
    logic [TUBE_W-1:0] rsel, rnew;
    logic [TUBE_W:0]   rsum;
    logic              clip, rok;
`ifdef CHG_EXACT_EN
    logic [AMT_W-1:0]  srem_q, srem_d;
    logic [TUBE_W-1:0] sn_q, sn_d, sd_q, sd_d, sq_q, sq_d;
    logic              xfail_q, xfail_d;
    logic [1:0]        spc;
`endif

    function automatic logic [1:0] pick(input logic [AMT_W-1:0] r,
                                        input logic [TUBE_W-1:0] n, d, q);
        return (r >= AMT_W'(25) && q != '0) ? 2'd3 :
               (r >= AMT_W'(10) && d != '0) ? 2'd2 :
               (r >= AMT_W'(5)  && n != '0) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [AMT_W-1:0] value(input logic [1:0] c);
        return c == 2'd3 ? AMT_W'(25) : c == 2'd2 ? AMT_W'(10) : c == 2'd1 ? AMT_W'(5) : '0;
    endfunction

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        short_d  = short_q;
        strobe_d = 1'b0;
        coin_d   = 2'd0;
        done_d   = 1'b0;
        // refill is applied first so a same-cycle accept sees the refilled tube
        rsel     = refill_coin == 2'd3 ? tq_q : refill_coin == 2'd2 ? td_q : tn_q;
        rsum     = {1'b0, rsel} + {1'b0, refill_count};
        clip     = rsum > (TUBE_W+1)'(TUBE_MAX);
        rnew     = clip ? TUBE_W'(TUBE_MAX) : rsum[TUBE_W-1:0];
        rok      = refill_valid && state_q == IDLE && refill_coin != 2'd0;
        rerr_d   = refill_valid && !(rok && !clip);
        tn_d     = rok && refill_coin == 2'd1 ? rnew : tn_q;
        td_d     = rok && refill_coin == 2'd2 ? rnew : td_q;
        tq_d     = rok && refill_coin == 2'd3 ? rnew : tq_q;
        pc       = pick(rem_q, tn_q, td_q, tq_q);
`ifdef CHG_EXACT_EN
        xfail_d  = 1'b0;
        srem_d   = srem_q;
        sn_d     = sn_q;
        sd_d     = sd_q;
        sq_d     = sq_q;
        spc      = pick(srem_q, sn_q, sd_q, sq_q);
`endif
        if (srst && state_q != IDLE && state_q != DONE) begin
            state_d = DONE;
            done_d  = 1'b1;
            short_d = rem_q;
        end else begin
            case (state_q)
                IDLE: if (chg_valid) begin
                    rem_d   = chg_amount;
                    short_d = '0;
`ifdef CHG_EXACT_EN
                    state_d = CHECK;
                    srem_d  = chg_amount;
                    sn_d    = tn_d;
                    sd_d    = td_d;
                    sq_d    = tq_d;
`else
                    state_d = DISPENSE;
`endif
                end
`ifdef CHG_EXACT_EN
                CHECK: if (srem_q == '0) state_d = DISPENSE;
                else if (spc != 2'd0) begin
                    srem_d = srem_q - value(spc);
                    sn_d   = sn_q - TUBE_W'(spc == 2'd1);
                    sd_d   = sd_q - TUBE_W'(spc == 2'd2);
                    sq_d   = sq_q - TUBE_W'(spc == 2'd3);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    short_d = rem_q;
                    xfail_d = 1'b1;
                end
`endif
                DISPENSE: if (pc != 2'd0) begin
                    strobe_d = 1'b1;
                    coin_d   = pc;
                    rem_d    = rem_q - value(pc);
                    tn_d     = tn_q - TUBE_W'(pc == 2'd1);
                    td_d     = td_q - TUBE_W'(pc == 2'd2);
                    tq_d     = tq_q - TUBE_W'(pc == 2'd3);
                    gap_d    = GW'(DISP_GAP);
                    state_d  = GAP;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    short_d = rem_q;
                end
                GAP: begin
                    gap_d   = gap_q - GW'(1);
                    state_d = gap_q == GW'(1) ? DISPENSE : GAP;
                end
                default: state_d = IDLE;
            endcase
        end
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            short_q  <= '0;
            gap_q    <= '0;
            tn_q     <= TUBE_W'(TUBE_INIT);
            td_q     <= TUBE_W'(TUBE_INIT);
            tq_q     <= TUBE_W'(TUBE_INIT);
            strobe_q <= 1'b0;
            coin_q   <= 2'd0;
            done_q   <= 1'b0;
            rerr_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            short_q  <= short_d;
            gap_q    <= gap_d;
            tn_q     <= tn_d;
            td_q     <= td_d;
            tq_q     <= tq_d;
            strobe_q <= strobe_d;
            coin_q   <= coin_d;
            done_q   <= done_d;
            rerr_q   <= rerr_d;
            ready_q  <= ready_d;
        end
    end

`ifdef CHG_EXACT_EN
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            srem_q  <= '0;
            sn_q    <= '0;
            sd_q    <= '0;
            sq_q    <= '0;
            xfail_q <= 1'b0;
        end else begin
            srem_q  <= srem_d;
            sn_q    <= sn_d;
            sd_q    <= sd_d;
            sq_q    <= sq_d;
            xfail_q <= xfail_d;
        end
    end
    assign exact_fail = xfail_q;
`else
    assign exact_fail = 1'b0;
`endif

    assign chg_ready   = ready_q;
    assign coin_strobe = strobe_q;
    assign coin_out    = coin_q;
    assign done        = done_q;
    assign shortfall   = short_q;
    assign refill_err  = rerr_q;
    assign tube_n      = tn_q;
    assign tube_d      = td_q;
    assign tube_q      = tq_q;
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb_vm2002_change_dispenser: randomized requests/refills/aborts against a greedy-payout timeline model.
module tb_vm2002_change_dispenser;
    localparam int AW = 16;
    localparam int TW = 6;

    logic          clk = 1'b0, hrst_n = 1'b0, srst = 1'b0, chg_valid = 1'b0;
    logic [AW-1:0] chg_amount = '0;
    logic          chg_ready, coin_strobe, done, exact_fail, refill_err;
    logic [1:0]    coin_out;
    logic [AW-1:0] shortfall;
    logic          refill_valid = 1'b0;
    logic [1:0]    refill_coin = 2'd0;
    logic [TW-1:0] refill_count = '0;
    logic [TW-1:0] tube_n, tube_d, tube_q;

    int ncmp = 0, nfail = 0;
    int mt[4];
    int vals[4] = '{0, 5, 10, 25};
    int seq, sf;

    always #5 clk = ~clk;

    vm2002_change_dispenser dut (
        .clk(clk), .hrst_n(hrst_n), .srst(srst), .chg_valid(chg_valid), .chg_amount(chg_amount),
        .chg_ready(chg_ready), .coin_strobe(coin_strobe), .coin_out(coin_out), .done(done),
        .shortfall(shortfall), .exact_fail(exact_fail), .refill_valid(refill_valid),
        .refill_coin(refill_coin), .refill_count(refill_count), .refill_err(refill_err),
        .tube_n(tube_n), .tube_d(tube_d), .tube_q(tube_q)
    );

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_tubes(input string tag);
        chk({tag, "_tube_n"}, int'(tube_n), mt[1]);
        chk({tag, "_tube_d"}, int'(tube_d), mt[2]);
        chk({tag, "_tube_q"}, int'(tube_q), mt[3]);
    endtask

    task automatic hard_reset;
        hrst_n = 1'b0;
        repeat (3) step();
        hrst_n = 1'b1;
        mt = '{0, 20, 20, 20};
        chk_tubes("reset");
        chk("reset_ready", chg_ready, 1);
        chk("reset_strobe", coin_strobe, 0);
        chk("reset_done", done, 0);
        chk("reset_shortfall", int'(shortfall), 0);
        chk("reset_rerr", refill_err, 0);
    endtask

    task automatic refill_idle(input int c, input int cnt);
        int s;
        bit err;
        refill_valid = 1'b1;
        refill_coin  = 2'(c);
        refill_count = TW'(cnt);
        step();
        refill_valid = 1'b0;
        err = (c == 0);
        if (c != 0) begin
            s = mt[c] + cnt;
            err = s > 50;
            mt[c] = s > 50 ? 50 : s;
        end
        chk("refill_err_idle", refill_err, int'(err));
        chk_tubes("refill");
    endtask

    task automatic idle_srst;
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("idle_srst_ready", chg_ready, 1);
        chk("idle_srst_done", done, 0);
        chk("idle_srst_strobe", coin_strobe, 0);
        chk_tubes("idle_srst");
    endtask

    // Timeline model: greedy coin list, strobe i at cycle 2+off+3i, done after last coin.
    task automatic run_txn(input int amt, input int abort_at, input int rf_busy_at, input bit rf_idle,
                           input int rf_coin, input int rf_cnt, output int oseq, output int osf);
        int t[4];
        int coins[$];
        int at[$];
        int r, n, off, done_at, paid, ec, c;
        bit err0, fail, xf;
        chk("ready_before", chg_ready, 1);
        chg_valid  = 1'b1;
        chg_amount = AW'(amt);
        if (rf_idle) begin
            refill_valid = 1'b1;
            refill_coin  = 2'(rf_coin);
            refill_count = TW'(rf_cnt);
        end
        step();
        chg_valid = 1'b0;
        refill_valid = 1'b0;
        err0 = 1'b0;
        if (rf_idle) begin
            if (rf_coin == 0) err0 = 1'b1;
            else begin
                r = mt[rf_coin] + rf_cnt;
                err0 = r > 50;
                mt[rf_coin] = r > 50 ? 50 : r;
            end
        end
        t = mt;
        r = amt;
        forever begin
            c = (r >= 25 && t[3] > 0) ? 3 : (r >= 10 && t[2] > 0) ? 2 : (r >= 5 && t[1] > 0) ? 1 : 0;
            if (c == 0) break;
            coins.push_back(c);
            t[c]--;
            r -= vals[c];
        end
        n = coins.size();
        fail = 1'b0;
        off = 0;
`ifdef CHG_EXACT_EN
        if (r != 0) begin
            fail = 1'b1;
            coins.delete();
        end else off = n + 1;
`endif
        done_at = fail ? 2 + n : 2 + off + 3 * n;
        foreach (coins[i]) at.push_back(2 + off + 3 * i);
        xf = fail;
        if (abort_at > 0 && abort_at < done_at) begin
            done_at = abort_at + 1;
            xf = 1'b0;
        end else abort_at = 0;
        if (rf_busy_at >= done_at) rf_busy_at = 0;
        oseq = 0;
        osf = 0;
        paid = 0;
        for (int cy = 1; cy <= done_at; cy++) begin
            ec = 0;
            foreach (at[i]) if (at[i] == cy && cy < done_at) ec = coins[i];
            if (ec != 0) begin
                mt[ec]--;
                paid += vals[ec];
            end
            chk("strobe", coin_strobe, int'(ec != 0));
            chk("coin_out", int'(coin_out), ec);
            chk("done", done, int'(cy == done_at));
            chk("ready_busy", chg_ready, 0);
            chk("exact_fail", exact_fail, int'(xf && cy == done_at));
            chk("refill_err", refill_err, int'((cy == 1 && err0) || (rf_busy_at > 0 && cy == rf_busy_at + 1)));
            chk_tubes("busy");
            if (cy == done_at) begin
                chk("shortfall", int'(shortfall), amt - paid);
                osf = int'(shortfall);
            end
            if (coin_strobe) oseq = (oseq << 2) | int'(coin_out);
            srst = (cy == abort_at);
            refill_valid = (cy == rf_busy_at);
            refill_coin  = 2'($urandom_range(0, 3));
            refill_count = TW'($urandom_range(0, 63));
            step();
            srst = 1'b0;
            refill_valid = 1'b0;
        end
        chk("ready_after", chg_ready, 1);
        chk("done_after", done, 0);
        chk("strobe_after", coin_strobe, 0);
        chk("shortfall_held", int'(shortfall), amt - paid);
        chk("rerr_after", refill_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        hard_reset();
        run_txn(65, 0, 0, 0, 0, 0, seq, sf);
        chk("lit65_seq", seq, 32'hF9);
        chk("lit65_sf", sf, 0);
        chk("lit65_tq", int'(tube_q), 18);
        chk("lit65_td", int'(tube_d), 19);
        chk("lit65_tn", int'(tube_n), 19);
        run_txn(7, 0, 0, 0, 0, 0, seq, sf);
`ifdef CHG_EXACT_EN
        chk("lit7_seq", seq, 0);
        chk("lit7_sf", sf, 7);
`else
        chk("lit7_seq", seq, 1);
        chk("lit7_sf", sf, 2);
`endif
        refill_idle(1, 45);
        chk("lit_refill_n", int'(tube_n), 50);
        chk("lit_refill_err", refill_err, 1);
        run_txn(0, 0, 0, 0, 0, 0, seq, sf);
        chk("lit0_seq", seq, 0);
        chk("lit0_sf", sf, 0);
        run_txn(30, 0, 3, 0, 0, 0, seq, sf);
        idle_srst();
        hard_reset();
`ifdef CHG_EXACT_EN
        run_txn(100, 7, 0, 0, 0, 0, seq, sf);
`else
        run_txn(100, 2, 0, 0, 0, 0, seq, sf);
`endif
        chk("lit100_seq", seq, 3);
        chk("lit100_sf", sf, 75);
        chk("lit100_tq", int'(tube_q), 19);
        chg_valid  = 1'b1;
        chg_amount = AW'(100);
        step();
        chg_valid = 1'b0;
        step();
        step();
`ifndef CHG_EXACT_EN
        chk("midop_tq_before", int'(tube_q), 18);
`endif
        hrst_n = 1'b0;
        #1;
        chk("midop_rst_tq", int'(tube_q), 20);
        chk("midop_rst_strobe", coin_strobe, 0);
        chk("midop_rst_ready", chg_ready, 1);
        @(negedge clk);
        hard_reset();
        run_txn(475, 0, 0, 0, 0, 0, seq, sf);
        repeat (9) run_txn(20, 0, 0, 0, 0, 0, seq, sf);
        run_txn(10, 0, 0, 0, 0, 0, seq, sf);
        repeat (19) run_txn(5, 0, 0, 0, 0, 0, seq, sf);
        chk("drain_t1", int'(tube_n) + int'(tube_d) + int'(tube_q), 3);
        run_txn(65, 0, 0, 0, 0, 0, seq, sf);
`ifdef CHG_EXACT_EN
        chk("lit_low_seq", seq, 0);
        chk("lit_low_sf", sf, 65);
`else
        chk("lit_low_seq", seq, 32'h39);
        chk("lit_low_sf", sf, 25);
`endif
        hard_reset();
        repeat (80) begin
            if ($urandom_range(0, 3) == 0) refill_idle($urandom_range(0, 3), $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) idle_srst();
            run_txn($urandom_range(0, 160),
                    $urandom_range(0, 3) == 0 ? $urandom_range(1, 20) : 0,
                    $urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 40), seq, sf);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
